// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared MDOp encodings, default latencies, FSM states and divide helper for md_unit
package md_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  // Returns {remainder, quotient}; quotient truncates toward zero and the
  // remainder follows the dividend's sign. 0x80000000 / -1 wraps to 0x80000000.
  function automatic logic [63:0] md_divide(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic        is_signed);
    logic        neg_a, neg_b;
    logic [31:0] ua, ub, q, r;
    neg_a = is_signed & a[31];
    neg_b = is_signed & b[31];
    ua    = neg_a ? -a : a;
    ub    = neg_b ? -b : b;
    q     = ua / ub;
    r     = ua % ub;
    if (neg_a ^ neg_b) q = -q;
    if (neg_a) r = -r;
    return {r, q};
  endfunction

endpackage

// File: rtl/md_unit.sv
// rtl/md_unit.sv - MIPS EX-stage multiply/divide unit with HI/LO; optional MD_DIVZERO_GUARD_EN keeps HI/LO on divide-by-zero
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        ReadSel,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDOut
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  md_state_e   state, state_d;
  logic [3:0]  cnt, cnt_d;
  logic [31:0] hi_n, lo_n, hi_n_d, lo_n_d;
  logic [31:0] hi_d, lo_d;
  md_op_e      op;
  logic [63:0] prod_s, prod_u, div_res;
  logic        div_zero;

  // Latency comes from the counter; the arithmetic itself is single-cycle behavioural.
  assign op       = md_op_e'(MDOp);
  assign prod_s   = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u   = {32'b0, A} * {32'b0, B};
  assign div_res  = md_divide(A, B, op == MD_DIV);
  assign div_zero = (B == 32'd0);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    hi_d    = HI;
    lo_d    = LO;
    hi_n_d  = hi_n;
    lo_n_d  = lo_n;
    if (state == ST_IDLE) begin
      if (Start && (op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU})) begin
        state_d = ST_BUSY;
        if (op == MD_MULT || op == MD_MULTU) begin
          cnt_d            = MULT_LOAD;
          {hi_n_d, lo_n_d} = (op == MD_MULT) ? prod_s : prod_u;
        end else begin
          cnt_d = DIV_LOAD;
          if (div_zero) begin
`ifdef MD_DIVZERO_GUARD_EN
            hi_n_d = HI;
            lo_n_d = LO;
`else
            hi_n_d = A;
            lo_n_d = 32'hFFFF_FFFF;
`endif
          end else begin
            {hi_n_d, lo_n_d} = div_res;
          end
        end
      end else if (!Start && op == MD_MTHI) begin
        hi_d = A;
      end else if (!Start && op == MD_MTLO) begin
        lo_d = A;
      end
    end else begin
      cnt_d = cnt - 4'd1;
      if (cnt == 4'd1) begin
        hi_d    = hi_n;
        lo_d    = lo_n;
        cnt_d   = 4'd0;
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
      HI    <= 32'd0;
      LO    <= 32'd0;
      hi_n  <= 32'd0;
      lo_n  <= 32'd0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      HI    <= hi_d;
      LO    <= lo_d;
      hi_n  <= hi_n_d;
      lo_n  <= lo_n_d;
    end
  end

  assign Busy  = (state == ST_BUSY);
  assign MDOut = ReadSel ? LO : HI;

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - scoreboard bench for md_unit; expectations follow MD_DIVZERO_GUARD_EN
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Start = 1'b0;
  logic [2:0]  MDOp = 3'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        ReadSel = 1'b0;
  logic        Busy;
  logic [31:0] HI, LO, MDOut;

  md_unit dut (
    .clk(clk), .reset(reset), .Start(Start), .MDOp(MDOp), .A(A), .B(B),
    .ReadSel(ReadSel), .Busy(Busy), .HI(HI), .LO(LO), .MDOut(MDOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic push(input string nm, input logic [31:0] hi, input logic [31:0] lo, input int cyc);
    exp_t e;
    e.name = nm; e.hi = hi; e.lo = lo; e.cycles = cyc;
    q.push_back(e);
  endtask

  // Entered and left just after a negedge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1; MDOp = op; A = a; B = b;
    @(negedge clk);
    Start = 1'b0; MDOp = 3'd0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while ((q.size() != 0 || Busy) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got busy=%0b pending=%0d expected idle with 0 pending", nm, Busy, q.size());
      q.delete();
    end
  endtask

  task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] hi, input logic [31:0] lo, input int cyc);
    push(nm, hi, lo, cyc);
    issue(op, a, b);
    wait_done(nm);
  endtask

  // Monitor: counts busy cycles and checks HI/LO in the cycle Busy falls.
  initial begin
    logic prev_busy;
    int   bcnt;
    exp_t e;
    prev_busy = 1'b0;
    bcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        bcnt = 0;
      end else if (Busy) begin
        bcnt++;
      end else if (prev_busy) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_commit: got HI=0x%08h LO=0x%08h expected no operation", HI, LO);
        end else begin
          e = q.pop_front();
          check({e.name, "_hi"}, HI, e.hi);
          check({e.name, "_lo"}, LO, e.lo);
          check({e.name, "_busy_cycles"}, 32'(bcnt), 32'(e.cycles));
        end
        bcnt = 0;
      end
      prev_busy = Busy;
    end
  end

  initial begin
    logic [31:0] dz_hi, dz_lo;
    int n;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    check("rst_mdout_hi", MDOut, 32'd0);
    ReadSel = 1'b1;
    #1 check("rst_mdout_lo", MDOut, 32'd0);
    ReadSel = 1'b0;
    @(negedge clk);

    run_op("mult", 3'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
    check("mult_mdout_hi", MDOut, 32'hFFFF_FFFF);
    ReadSel = 1'b1;
    #1 check("mult_mdout_lo", MDOut, 32'hFFFF_FFFA);
    ReadSel = 1'b0;

    run_op("multu", 3'd2, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE, 5);

    // div -7/2 with Start, mthi and mtlo poked while busy; all must be ignored
    push("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    issue(3'd3, 32'hFFFF_FFF9, 32'd2);
    repeat (2) @(negedge clk);
    Start = 1'b1; MDOp = 3'd2; A = 32'd5; B = 32'd5;
    @(negedge clk);
    Start = 1'b0; MDOp = 3'd5; A = 32'hDEAD;
    @(negedge clk);
    MDOp = 3'd6;
    @(negedge clk);
    MDOp = 3'd0;
    wait_done("div_neg");
    repeat (3) @(negedge clk);
    check("div_neg_no_restart", {31'd0, Busy}, 32'd0);

    run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10);

    MDOp = 3'd5; A = 32'h11;
    @(negedge clk);
    MDOp = 3'd6; A = 32'h22;
    check("mthi_hi", HI, 32'h11);
    check("mthi_busy", {31'd0, Busy}, 32'd0);
    @(negedge clk);
    MDOp = 3'd0;
    check("mtlo_lo", LO, 32'h22);
    check("mtlo_hi_kept", HI, 32'h11);

`ifdef MD_DIVZERO_GUARD_EN
    dz_hi = 32'h11; dz_lo = 32'h22;
`else
    dz_hi = 32'h55; dz_lo = 32'hFFFF_FFFF;
`endif
    run_op("divu_zero", 3'd4, 32'h55, 32'd0, dz_hi, dz_lo, 10);

    // Start with reserved op and with mthi encoding: neither starts nor writes
    issue(3'd7, 32'hAAAA, 32'd3);
    issue(3'd5, 32'hBBBB, 32'd3);
    @(negedge clk);
    check("ignored_busy", {31'd0, Busy}, 32'd0);
    check("ignored_hi", HI, dz_hi);
    check("ignored_lo", LO, dz_lo);

    // Back-to-back: second Start in the first idle cycle after Busy falls
    push("b2b_multu", 32'd0, 32'd12, 5);
    push("b2b_divu", 32'd2, 32'd14, 10);
    issue(3'd2, 32'd3, 32'd4);
    n = 0;
    while (Busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("b2b_first_idle_hi", HI, 32'd0);
    check("b2b_first_idle_lo", LO, 32'd12);
    issue(3'd4, 32'd100, 32'd7);
    wait_done("b2b");

    // mthi then a div aborted by reset in busy cycle 4
    MDOp = 3'd5; A = 32'h1234;
    @(negedge clk);
    MDOp = 3'd0;
    check("mthi2_hi", HI, 32'h1234);
    check("mthi2_busy", {31'd0, Busy}, 32'd0);
    issue(3'd3, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", {31'd0, Busy}, 32'd0);
    check("abort_hi", HI, 32'd0);
    check("abort_lo", LO, 32'd0);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    check("abort_late_busy", {31'd0, Busy}, 32'd0);
    check("abort_late_hi", HI, 32'd0);
    check("abort_late_lo", LO, 32'd0);
    check("scoreboard_empty", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
